// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared types and constants for the two-requester round-robin arbiter:
// FSM state encoding, default datapath/hold sizing and the stats saturation value.
package mux2_rr_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GNT_A = 2'd1,
      ST_GNT_B = 2'd2
   } state_t;

   localparam int          DEF_WIDTH    = 16;
   localparam int          DEF_MAX_HOLD = 4;
   localparam logic [15:0] CNT_SAT      = 16'hFFFF;

   // clog2(max_hold)+1 is never below 1, so MAX_HOLD=0 still gets a 1-bit counter.
   function automatic int hold_width(input int max_hold);
      return $clog2(max_hold) + 1;
   endfunction

endpackage

// File: rtl/mux2_rr_arbiter_mux.sv
// Enabled 2:1 datapath mux shared by the two requesters; output is zero while disabled.
module mux2_rr_arbiter_mux #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sel,
   input  logic             en,
   output logic [WIDTH-1:0] y
);

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         assign y[gi] = en & (sel ? b[gi] : a[gi]);
      end
   endgenerate

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter for two bursting producers feeding one registered valid/ready output stage.
// Optional per-requester beat counters are built when MUX2_RR_ARBITER_STATS_EN is defined.
module mux2_rr_arbiter
   import mux2_rr_arbiter_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int MAX_HOLD = DEF_MAX_HOLD
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_a,
   input  logic             last_a,
   input  logic [WIDTH-1:0] data_a,
   input  logic             req_b,
   input  logic             last_b,
   input  logic [WIDTH-1:0] data_b,
   output logic             gnt_a,
   output logic             gnt_b,
   output logic             mux_sel,
   output logic             mux_en,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      cnt_a,
   output logic [15:0]      cnt_b
);

   localparam int                HOLD_W    = hold_width(MAX_HOLD);
   localparam bit                LIMITED   = (MAX_HOLD != 0);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

   state_t            state_reg, state_next;
   logic              prio_reg, prio_next;   // 0 = A has priority, 1 = B
   logic [HOLD_W-1:0] hold_reg, hold_next;
   logic              out_valid_reg;
   logic [WIDTH-1:0]  out_data_reg;
   logic [WIDTH-1:0]  mux_y;

   logic in_ready;
   logic owner_req, owner_last, other_req;
   logic beat, at_limit, grant_end;

   assign gnt_a     = (state_reg == ST_GNT_A);
   assign gnt_b     = (state_reg == ST_GNT_B);
   assign mux_sel   = (state_reg == ST_GNT_B);
   assign mux_en    = (state_reg != ST_IDLE);
   assign out_data  = out_data_reg;
   assign out_valid = out_valid_reg;

   mux2_rr_arbiter_mux #(.WIDTH(WIDTH)) u_mux (
      .a   (data_a),
      .b   (data_b),
      .sel (mux_sel),
      .en  (mux_en),
      .y   (mux_y)
   );

   assign in_ready = ~out_valid_reg | out_ready;

   always_comb begin
      owner_req  = 1'b0;
      owner_last = 1'b0;
      other_req  = 1'b0;
      case (state_reg)
         ST_GNT_A: begin
            owner_req  = req_a;
            owner_last = last_a;
            other_req  = req_b;
         end
         ST_GNT_B: begin
            owner_req  = req_b;
            owner_last = last_b;
            other_req  = req_a;
         end
         default: ;
      endcase
   end

   assign beat      = owner_req & in_ready;
   assign at_limit  = LIMITED & (hold_reg == HOLD_LAST);
   assign grant_end = mux_en & (~owner_req | (beat & (owner_last | (at_limit & other_req))));

   always_comb begin
      state_next = state_reg;
      prio_next  = prio_reg;
      hold_next  = hold_reg;
      case (state_reg)
         ST_IDLE: begin
            if (req_a & (~req_b | ~prio_reg)) begin
               state_next = ST_GNT_A;
            end else if (req_b) begin
               state_next = ST_GNT_B;
            end
         end
         ST_GNT_A: begin
            if (grant_end) begin
               state_next = req_b ? ST_GNT_B : ST_IDLE;
               prio_next  = 1'b1;
               hold_next  = '0;
            end else if (beat & ~at_limit) begin
               hold_next = hold_reg + 1'b1;
            end
         end
         ST_GNT_B: begin
            if (grant_end) begin
               state_next = req_a ? ST_GNT_A : ST_IDLE;
               prio_next  = 1'b0;
               hold_next  = '0;
            end else if (beat & ~at_limit) begin
               // Parks at the limit so a late-arriving competitor takes over on the next beat.
               hold_next = hold_reg + 1'b1;
            end
         end
         default: begin
            state_next = ST_IDLE;
            hold_next  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         prio_reg      <= 1'b0;
         hold_reg      <= '0;
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
      end else begin
         state_reg <= state_next;
         prio_reg  <= prio_next;
         hold_reg  <= hold_next;
         if (beat) begin
            out_data_reg  <= mux_y;
            out_valid_reg <= 1'b1;
         end else if (out_ready) begin
            out_valid_reg <= 1'b0;
         end
      end
   end

`ifdef MUX2_RR_ARBITER_STATS_EN
   logic [15:0] cnt_a_reg, cnt_b_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_a_reg <= '0;
         cnt_b_reg <= '0;
      end else begin
         if (beat && gnt_a && (cnt_a_reg != CNT_SAT)) begin
            cnt_a_reg <= cnt_a_reg + 16'd1;
         end
         if (beat && gnt_b && (cnt_b_reg != CNT_SAT)) begin
            cnt_b_reg <= cnt_b_reg + 16'd1;
         end
      end
   end

   assign cnt_a = cnt_a_reg;
   assign cnt_b = cnt_b_reg;
`else
   assign cnt_a = 16'h0000;
   assign cnt_b = 16'h0000;
`endif

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Self-checking bench for mux2_rr_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level arbitration model.
module tb_mux2_rr_arbiter;

   localparam int WIDTH    = 16;
   localparam int MAX_HOLD = 4;
`ifdef MUX2_RR_ARBITER_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_a = 1'b0, last_a = 1'b0, req_b = 1'b0, last_b = 1'b0;
   logic [15:0] data_a = '0, data_b = '0;
   logic        out_ready = 1'b1;
   logic        gnt_a, gnt_b, mux_sel, mux_en, out_valid;
   logic [15:0] out_data, cnt_a, cnt_b;

   mux2_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_a     (req_a),
      .last_a    (last_a),
      .data_a    (data_a),
      .req_b     (req_b),
      .last_b    (last_b),
      .data_b    (data_b),
      .gnt_a     (gnt_a),
      .gnt_b     (gnt_b),
      .mux_sel   (mux_sel),
      .mux_en    (mux_en),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .cnt_a     (cnt_a),
      .cnt_b     (cnt_b)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   bit verbose  = 1'b0;

   // Producer queues: pending beats of each requester, head is the beat on offer.
   logic [15:0] qd_a[$], qd_b[$];
   bit          ql_a[$], ql_b[$];
   bit          en_a = 1'b1, en_b = 1'b1;
   logic [15:0] acc[$];

   // Reference model: who owns the path, who has priority, beats in the current grant.
   int          m_owner, m_prio, m_run;
   bit          m_valid;
   logic [15:0] m_data;
   int          m_cnt_a, m_cnt_b;

   task automatic push_burst(input int side, input int len, input logic [15:0] base);
      for (int i = 0; i < len; i++) begin
         if (side == 0) begin
            qd_a.push_back(base + 16'(i));
            ql_a.push_back(i == len - 1);
         end else begin
            qd_b.push_back(base + 16'(i));
            ql_b.push_back(i == len - 1);
         end
      end
   endtask

   task automatic drive_inputs();
      req_a  = en_a && (qd_a.size() != 0);
      data_a = (qd_a.size() != 0) ? qd_a[0] : 16'h0;
      last_a = (ql_a.size() != 0) ? ql_a[0] : 1'b0;
      req_b  = en_b && (qd_b.size() != 0);
      data_b = (qd_b.size() != 0) ? qd_b[0] : 16'h0;
      last_b = (ql_b.size() != 0) ? ql_b[0] : 1'b0;
   endtask

   task automatic model_step();
      bit          r[2];
      bit          l[2];
      logic [15:0] d[2];
      bit          room, bt, fin;
      int          o, x;
      r[0] = req_a;  r[1] = req_b;
      l[0] = last_a; l[1] = last_b;
      d[0] = data_a; d[1] = data_b;
      room = !m_valid || out_ready;
      if (m_owner < 0) begin
         if (out_ready) m_valid = 1'b0;
         if (r[0] && r[1])  m_owner = m_prio;
         else if (r[0])     m_owner = 0;
         else if (r[1])     m_owner = 1;
      end else begin
         o   = m_owner;
         x   = 1 - o;
         bt  = r[o] && room;
         fin = !r[o] || (bt && (l[o] || (MAX_HOLD != 0 && m_run + 1 >= MAX_HOLD && r[x])));
         if (bt) begin
            m_data  = d[o];
            m_valid = 1'b1;
            if (o == 0) begin
               if (STATS && m_cnt_a < 65535) m_cnt_a++;
               void'(qd_a.pop_front());
               void'(ql_a.pop_front());
            end else begin
               if (STATS && m_cnt_b < 65535) m_cnt_b++;
               void'(qd_b.pop_front());
               void'(ql_b.pop_front());
            end
         end else if (out_ready) begin
            m_valid = 1'b0;
         end
         if (fin) begin
            m_owner = r[x] ? x : -1;
            m_prio  = x;
            m_run   = 0;
         end else if (bt) begin
            m_run++;
         end
      end
   endtask

   // One clock: present inputs, log any accepted output beat, advance model, step past the edge.
   task automatic cycle();
      drive_inputs();
      if (out_valid && out_ready) begin
         acc.push_back(out_data);
         if (verbose) $display("[%0t] beat accepted: out_data=%h", $time, out_data);
      end
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      qd_a.delete(); ql_a.delete(); qd_b.delete(); ql_b.delete();
      acc.delete();
      en_a = 1'b1; en_b = 1'b1; out_ready = 1'b1;
      drive_inputs();
      m_owner = -1; m_prio = 0; m_run = 0; m_valid = 1'b0; m_data = '0;
      m_cnt_a = 0;  m_cnt_b = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      n_checks++;
      if ({gnt_a, gnt_b, mux_sel, mux_en, out_valid} !== 5'b0 || out_data !== 16'h0 ||
          cnt_a !== 16'h0 || cnt_b !== 16'h0) begin
         n_errors++;
         $display("FAIL reset_state: gnt_a=%b gnt_b=%b sel=%b en=%b valid=%b data=%h cnt=%h/%h, required all zero",
                  gnt_a, gnt_b, mux_sel, mux_en, out_valid, out_data, cnt_a, cnt_b);
      end
      push_burst(1, 4, 16'hB100);
      cycle();
      cycle();
      n_checks++;
      if (gnt_b !== 1'b1 || out_valid !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_setup: gnt_b=%b out_valid=%b, required 1/1", gnt_b, out_valid);
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (gnt_b !== 1'b0 || mux_en !== 1'b0 || out_valid !== 1'b0 || out_data !== 16'h0) begin
         n_errors++;
         $display("FAIL reset_midburst: gnt_b=%b mux_en=%b out_valid=%b out_data=%h, required 0/0/0/0000",
                  gnt_b, mux_en, out_valid, out_data);
      end
      apply_reset();
      push_burst(0, 1, 16'hA0A0);
      push_burst(1, 1, 16'hB0B0);
      cycle();
      n_checks++;
      if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_prio: gnt_a=%b gnt_b=%b, required 1/0", gnt_a, gnt_b);
      end
   endtask

   task automatic test_simultaneous();
      apply_reset();
      push_burst(0, 1, 16'h1111);
      push_burst(1, 1, 16'h2222);
      cycle();
      n_checks++;
      if (gnt_a !== 1'b1 || gnt_b !== 1'b0 || mux_sel !== 1'b0) begin
         n_errors++;
         $display("FAIL simul_cycle1: gnt_a=%b gnt_b=%b sel=%b, required 1/0/0", gnt_a, gnt_b, mux_sel);
      end
      cycle();
      n_checks++;
      if (gnt_a !== 1'b0 || gnt_b !== 1'b1 || mux_sel !== 1'b1 || out_data !== 16'h1111 || out_valid !== 1'b1) begin
         n_errors++;
         $display("FAIL simul_cycle2: gnt_a=%b gnt_b=%b sel=%b data=%h valid=%b, required 0/1/1/1111/1",
                  gnt_a, gnt_b, mux_sel, out_data, out_valid);
      end
      cycle();
      n_checks++;
      if (gnt_b !== 1'b0 || mux_en !== 1'b0 || out_data !== 16'h2222 || out_valid !== 1'b1) begin
         n_errors++;
         $display("FAIL simul_cycle3: gnt_b=%b mux_en=%b data=%h valid=%b, required 0/0/2222/1",
                  gnt_b, mux_en, out_data, out_valid);
      end
   endtask

   task automatic test_hold_limit();
      logic [15:0] exp[$];
      apply_reset();
      push_burst(0, 8, 16'hA000);
      push_burst(1, 1, 16'hB000);
      for (int i = 0; i < 4; i++) exp.push_back(16'hA000 + 16'(i));
      exp.push_back(16'hB000);
      for (int i = 4; i < 8; i++) exp.push_back(16'hA000 + 16'(i));
      repeat (14) cycle();
      n_checks++;
      if (acc.size() != exp.size()) begin
         n_errors++;
         $display("FAIL hold_count: got %0d beats, required %0d", acc.size(), exp.size());
      end
      for (int i = 0; i < exp.size() && i < acc.size(); i++) begin
         n_checks++;
         if (acc[i] !== exp[i]) begin
            n_errors++;
            $display("FAIL hold_order[%0d]: got %h, required %h", i, acc[i], exp[i]);
         end
      end
   endtask

   task automatic test_no_forced_handover();
      apply_reset();
      push_burst(0, 8, 16'hC000);
      for (int i = 1; i <= 8; i++) begin
         cycle();
         n_checks++;
         if (gnt_a !== 1'b1) begin
            n_errors++;
            $display("FAIL noforce_gnt cycle %0d: gnt_a=%b, required 1", i, gnt_a);
         end
      end
      cycle();
      n_checks++;
      if (gnt_a !== 1'b0 || mux_en !== 1'b0) begin
         n_errors++;
         $display("FAIL noforce_idle: gnt_a=%b mux_en=%b, required 0/0", gnt_a, mux_en);
      end
      cycle();
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (i >= acc.size() || acc[i] !== 16'hC000 + 16'(i)) begin
            n_errors++;
            $display("FAIL noforce_beat[%0d]: got %h (of %0d), required %h", i,
                     (i < acc.size()) ? acc[i] : 16'hxxxx, acc.size(), 16'hC000 + 16'(i));
         end
      end
   endtask

   task automatic test_back_pressure();
      logic [15:0] exp[$];
      apply_reset();
      push_burst(0, 6, 16'hA000);
      push_burst(1, 1, 16'hB000);
      repeat (3) cycle();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== 16'hA001 || gnt_a !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_stall cycle %0d: valid=%b data=%h gnt_a=%b, required 1/a001/1",
                     i, out_valid, out_data, gnt_a);
         end
      end
      out_ready = 1'b1;
      repeat (10) cycle();
      for (int i = 0; i < 4; i++) exp.push_back(16'hA000 + 16'(i));
      exp.push_back(16'hB000);
      exp.push_back(16'hA004);
      exp.push_back(16'hA005);
      n_checks++;
      if (acc.size() != exp.size()) begin
         n_errors++;
         $display("FAIL bp_count: got %0d beats, required %0d", acc.size(), exp.size());
      end
      for (int i = 0; i < exp.size() && i < acc.size(); i++) begin
         n_checks++;
         if (acc[i] !== exp[i]) begin
            n_errors++;
            $display("FAIL bp_order[%0d]: got %h, required %h", i, acc[i], exp[i]);
         end
      end
   endtask

   task automatic test_stats();
      logic [15:0] exp_a, exp_b;
      apply_reset();
      push_burst(0, 3, 16'hD000);
      push_burst(1, 5, 16'hE000);
      repeat (12) cycle();
      exp_a = STATS ? 16'd3 : 16'd0;
      exp_b = STATS ? 16'd5 : 16'd0;
      n_checks++;
      if (cnt_a !== exp_a || cnt_b !== exp_b) begin
         n_errors++;
         $display("FAIL stats_count: cnt_a=%h cnt_b=%h, required %h/%h", cnt_a, cnt_b, exp_a, exp_b);
      end
`ifdef MUX2_RR_ARBITER_STATS_EN
      force dut.cnt_a_reg = 16'hFFFE;
      #1 release dut.cnt_a_reg;
      m_cnt_a = 32'hFFFE;
`endif
      push_burst(0, 3, 16'hD100);
      repeat (6) cycle();
      exp_a = STATS ? 16'hFFFF : 16'd0;
      n_checks++;
      if (cnt_a !== exp_a) begin
         n_errors++;
         $display("FAIL stats_saturate: cnt_a=%h, required %h", cnt_a, exp_a);
      end
   endtask

   task automatic test_random();
      apply_reset();
      verbose = 1'b0;
      for (int cyc = 0; cyc < 3000 && n_errors < 50; cyc++) begin
         if (qd_a.size() < 4 && $urandom_range(0, 3) == 0)
            push_burst(0, $urandom_range(1, 9), 16'($urandom));
         if (qd_b.size() < 4 && $urandom_range(0, 3) == 0)
            push_burst(1, $urandom_range(1, 9), 16'($urandom));
         en_a      = ($urandom_range(0, 9) != 0);
         en_b      = ($urandom_range(0, 9) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         cycle();
         n_checks++;
         if (gnt_a !== (m_owner == 0) || gnt_b !== (m_owner == 1) ||
             mux_sel !== (m_owner == 1) || mux_en !== (m_owner >= 0)) begin
            n_errors++;
            $display("FAIL rand_grant cycle %0d: gnt_a=%b gnt_b=%b sel=%b en=%b, required owner %0d",
                     cyc, gnt_a, gnt_b, mux_sel, mux_en, m_owner);
         end
         n_checks++;
         if (out_valid !== m_valid || out_data !== m_data) begin
            n_errors++;
            $display("FAIL rand_output cycle %0d: valid=%b data=%h, required %b/%h",
                     cyc, out_valid, out_data, m_valid, m_data);
         end
         n_checks++;
         if (cnt_a !== 16'(m_cnt_a) || cnt_b !== 16'(m_cnt_b)) begin
            n_errors++;
            $display("FAIL rand_stats cycle %0d: cnt_a=%h cnt_b=%h, required %h/%h",
                     cyc, cnt_a, cnt_b, 16'(m_cnt_a), 16'(m_cnt_b));
         end
      end
   endtask

   initial begin
      verbose = 1'b1;
      test_reset();
      test_simultaneous();
      test_hold_limit();
      test_no_forced_handover();
      test_back_pressure();
      test_stats();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mux2_rr_arbiter.md
Name: mux2_rr_arbiter

Overview:
- Two-requester round-robin arbiter that shares the 16-bit 2:1 select datapath between requester A and requester B.
- Drives the mux select/enable and owns one registered output stage with a valid/ready handshake.
- Supports multi-beat bursts, with a fairness cap on consecutive beats.
- Sits between two producers (for example, ALU writeback and load return) and a single 16-bit consumer such as the register-file write port.

Parameters:
- WIDTH, 16, datapath width of data_a, data_b and out_data.
- MAX_HOLD, 4, maximum consecutive beats per grant while the other requester waits. 0 means unlimited (grant ends only on last or on req drop).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_a  in  1  requester A has a beat available.
- last_a  in  1  current A beat ends A's burst.
- data_a  in  WIDTH  A payload.
- req_b  in  1  requester B has a beat available.
- last_b  in  1  current B beat ends B's burst.
- data_b  in  WIDTH  B payload.
- gnt_a  out  1  A owns the datapath (registered).
- gnt_b  out  1  B owns the datapath (registered).
- mux_sel  out  1  datapath select, 0=A, 1=B.
- mux_en  out  1  datapath enable; 1 whenever a grant is held.
- out_data  out  WIDTH  registered output payload.
- out_valid  out  1  out_data holds a beat.
- out_ready  in  1  consumer accepts out_data this cycle.
- cnt_a  out  16  granted-beat count for A (see Optional Feature).
- cnt_b  out  16  granted-beat count for B (see Optional Feature).

Behaviour:
- Reset (async, immediate, legal mid-burst): state=IDLE, prio=A, hold counter=0, gnt_a=gnt_b=0, mux_sel=0, mux_en=0, out_valid=0, out_data=0, cnt_a=cnt_b=0. An in-flight burst is dropped; requesters re-request after reset.
- States: IDLE, GNT_A, GNT_B. gnt_a=(state==GNT_A), gnt_b=(state==GNT_B), mux_sel=(state==GNT_B), mux_en=(state!=IDLE).
- in_ready = ~out_valid | out_ready. beat = (GNT_A & req_a | GNT_B & req_b) & in_ready.
- Output stage:
  - On beat: out_data <= mux output, out_valid <= 1.
  - Else if out_ready: out_valid <= 0, out_data holds.
  - Full throughput: one beat per cycle while out_ready=1.
- IDLE transitions:
  - Only req_a: go to GNT_A. Only req_b: go to GNT_B.
  - Both: grant the prio side.
  - Neither: stay in IDLE.
  - Latency from req to grant is 1 cycle; the first beat can transfer in the first cycle gnt is high.
- Grant ends at the clock edge when any of the following holds:
  - (a) beat with the owner's last=1;
  - (b) beat where hold counter==MAX_HOLD-1, MAX_HOLD!=0 and the other req=1;
  - (c) owner req=0 (release without transfer).
- At grant end:
  - Next state = the other side's grant if its req=1, else IDLE. No idle bubble on handover.
  - prio <= the other side; hold counter <= 0.
- Hold counter: increments on each beat that does not end the grant. Width is clog2(MAX_HOLD)+1, with a minimum of 1.
- Back-pressure: when out_ready=0 and out_valid=1 there is no beat; grant, counter and state hold. The hold limit counts beats, not cycles.
- last is sampled only on a beat; last with req=0 is ignored.
- Owner req=1 with the other idle: counter saturation never forces release. The grant continues until last or req drop.

Optional Feature:
- Macro: MUX2_RR_ARBITER_STATS_EN.
- Defined: cnt_a and cnt_b increment on each A and B beat respectively, saturating at 16'hFFFF, cleared only by rst.
- Undefined: the counter logic is compiled out and cnt_a=cnt_b=16'h0000 constant. Ports remain, so instantiations are unchanged.

Decomposition:
- Shared package/header holds:
  - state encodings ST_IDLE=2'd0, ST_GNT_A=2'd1, ST_GNT_B=2'd2;
  - the default WIDTH=16 and MAX_HOLD=4 constants;
  - the saturation constant 16'hFFFF.
- One natural sub-module: the existing 16-bit 2:1 enabled mux, instantiated once as the datapath. Its a/b inputs are data_a/data_b and its sel/en inputs are mux_sel/mux_en.
- The FSM, hold counter, output stage and stats counters stay in this module.

Test Plan:
- Reset state: assert rst mid-burst while in GNT_B with out_valid=1 -> same cycle gnt_b=0, mux_en=0, out_valid=0, out_data=0. After release, req_a=req_b=1 grants A first (prio reset to A).
- Simultaneous single beats: req_a=req_b=1, last_a=last_b=1, data_a=16'h1111, data_b=16'h2222, out_ready=1 -> gnt_a in cycle 1, gnt_b in cycle 2 (no bubble). out_data=1111 then 2222 on consecutive cycles.
- Hold limit: A bursts 8 beats (last only on beat 8) with req_b=1 and MAX_HOLD=4 -> A gets 4 beats, B gets its burst, then A resumes. Order is A×4, B, A×4.
- No forced handover: A bursts 8 beats with req_b=0 -> all 8 beats transfer under continuous gnt_a; IDLE after last.
- Back-pressure: out_ready=0 for 5 cycles mid-burst -> out_valid stays 1, out_data stable, hold counter frozen, no beat lost or duplicated. After out_ready=1, the remaining beats arrive in order.
- Stats: with MUX2_RR_ARBITER_STATS_EN defined, after 3 A beats and 5 B beats -> cnt_a=3, cnt_b=5. Preloading by forcing to 16'hFFFE then driving 3 beats -> 16'hFFFF. With the macro undefined -> both read 0.
